bnn_pe_array_stream: RTL and testbench

BNN_PE_ARRAY_STREAM -- requirements
Module: bnn_pe_array_stream

---
 rtl/bnn_pe_array_stream.sv | 142 ++++++++++++++
 tb/tb_bnn_pe_array_stream.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bnn_pe_array_stream.sv
// Binarised-NN PE array: O_CH rows of XNOR-popcount accumulators fed by one
// interleaved weight/activation stream, drained one row per output handshake.
module bnn_pe_array_stream #(
    parameter int DATA_W     = 27,
    parameter int ROW_LENGTH = 11,
    parameter int O_CH       = 8,
    parameter int K          = 10,
    parameter int PSUM_W     = 14,
    parameter int THRESH     = 1485
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              bin_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PSUM_W-1:0] psum_out,
    output logic              out_last
);

    localparam int GROUPS = ROW_LENGTH * K;
    localparam int WORD_W = $clog2(O_CH + 1);
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int IDX_W  = (O_CH > 1) ? $clog2(O_CH) : 1;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int SUM_W  = ((PSUM_W > CNT_W) ? PSUM_W : CNT_W) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({PSUM_W{1'b1}});

    typedef enum logic {ACC, DRAIN} state_t;

    state_t            state;
    logic [WORD_W-1:0] word_cnt;
    logic [GRP_W-1:0]  group_cnt;
    logic [IDX_W-1:0]  idx;
    logic              mode_q;
    logic [DATA_W-1:0] weight [O_CH];
    logic [PSUM_W-1:0] acc    [O_CH];
    logic [PSUM_W-1:0] acc_next [O_CH];
    logic [SUM_W-1:0]  sum      [O_CH];

    logic in_fire, out_fire, is_act, last_group, last_row;

    function automatic logic [CNT_W-1:0] popcount(input logic [DATA_W-1:0] x);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DATA_W; i++) begin
            cnt = cnt + CNT_W'(x[i]);
        end
        return cnt;
    endfunction

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign is_act     = (word_cnt == WORD_W'(O_CH));
    assign last_group = (group_cnt == GRP_W'(GROUPS - 1));
    assign last_row   = (idx == IDX_W'(O_CH - 1));

    // XNOR-popcount per row, clamped so the accumulator never wraps
    always_comb begin
        for (int r = 0; r < O_CH; r++) begin
            sum[r]      = SUM_W'(acc[r]) + SUM_W'(popcount(~(weight[r] ^ data_in)));
            acc_next[r] = (sum[r] > ACC_MAX) ? {PSUM_W{1'b1}} : sum[r][PSUM_W-1:0];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= ACC;
            word_cnt  <= '0;
            group_cnt <= '0;
            idx       <= '0;
            mode_q    <= 1'b0;
            for (int r = 0; r < O_CH; r++) begin
                weight[r] <= '0;
                acc[r]    <= '0;
            end
        end else begin
            case (state)
                ACC: begin
                    if (in_fire) begin
                        if (is_act) begin
                            word_cnt <= '0;
                            for (int r = 0; r < O_CH; r++) begin
                                acc[r] <= acc_next[r];
                            end
                            if (last_group) begin
                                group_cnt <= '0;
                                idx       <= '0;
                                mode_q    <= bin_mode;
                                state     <= DRAIN;
                            end else begin
                                group_cnt <= group_cnt + GRP_W'(1);
                            end
                        end else begin
                            for (int r = 0; r < O_CH; r++) begin
                                if (word_cnt == WORD_W'(r)) begin
                                    weight[r] <= data_in;
                                end
                            end
                            word_cnt <= word_cnt + WORD_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (last_row) begin
                            // weights stay loaded; only the accumulation state restarts
                            idx       <= '0;
                            word_cnt  <= '0;
                            group_cnt <= '0;
                            for (int r = 0; r < O_CH; r++) begin
                                acc[r] <= '0;
                            end
                            state <= ACC;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    assign in_ready  = (state == ACC) && !rst_in;
    assign out_valid = (state == DRAIN);
    assign out_last  = out_valid && last_row;

    always_comb begin
        psum_out = '0;
        if (out_valid) begin
            if (mode_q) begin
                psum_out[0] = ({{(32 - PSUM_W){1'b0}}, acc[idx]} >= $unsigned(THRESH));
            end else begin
                psum_out = acc[idx];
            end
        end
    end

endmodule

// File: tb/tb_bnn_pe_array_stream.sv
// Self-checking bench for bnn_pe_array_stream: drives default and PSUM_W=11
// instances from one stream and compares both against a popcount reference.
module tb_bnn_pe_array_stream;

    localparam int DATA_W     = 27;
    localparam int ROW_LENGTH = 11;
    localparam int O_CH       = 8;
    localparam int K          = 10;
    localparam int GROUPS     = ROW_LENGTH * K;
    localparam int THRESH     = 1485;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              bin_mode = 1'b0;
    logic              out_ready = 1'b1;

    logic              in_ready, out_valid, out_last;
    logic [13:0]       psum_out;
    logic              in_ready_s, out_valid_s, out_last_s;
    logic [10:0]       psum_out_s;

    int assert_count = 0;
    int fail_count   = 0;
    int exp_full [O_CH];
    int exp_sat  [O_CH];

    bnn_pe_array_stream dut (
        .clk_in(clk), .rst_in(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .bin_mode(bin_mode), .out_valid(out_valid),
        .out_ready(out_ready), .psum_out(psum_out), .out_last(out_last)
    );

    bnn_pe_array_stream #(.PSUM_W(11)) dut_s (
        .clk_in(clk), .rst_in(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .data_in(data_in), .bin_mode(bin_mode), .out_valid(out_valid_s),
        .out_ready(out_ready), .psum_out(psum_out_s), .out_last(out_last_s)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // pattern 0: all ones; 1: weights ones, acts zeros; 2: even rows ones, odd zeros, acts ones; 3: random
    function automatic logic [DATA_W-1:0] gen_word(input int pattern, input bit is_act, input int row);
        case (pattern)
            0: return '1;
            1: return is_act ? '0 : '1;
            2: return (is_act || (row % 2 == 0)) ? '1 : '0;
            default: return DATA_W'($urandom);
        endcase
    endfunction

    task automatic send_word(input logic [DATA_W-1:0] w, input bit gaps, input bit last);
        int wait_n;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                data_in  = DATA_W'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = w;
        wait_n   = 0;
        while (!in_ready && wait_n < 16) begin
            @(negedge clk);
            wait_n++;
        end
        check_output("in_ready", 32'(in_ready), 32'd1);
        if (last) check_output("out_valid_before_last", 32'(out_valid), 32'd0);
        @(posedge clk);
    endtask

    // Streams one output set (or stops after max_words) and builds the expected results
    task automatic apply_stimulus(input int pattern, input bit mode, input bit gaps, input int max_words);
        int sum [O_CH];
        logic [DATA_W-1:0] wreg [O_CH];
        logic [DATA_W-1:0] wv;
        int sent;
        int v;
        sent     = 0;
        bin_mode = mode;
        for (int r = 0; r < O_CH; r++) begin
            sum[r]  = 0;
            wreg[r] = '0;
        end
        for (int g = 0; g < GROUPS; g++) begin
            for (int s = 0; s <= O_CH; s++) begin
                if (sent == max_words) return;
                wv = gen_word(pattern, s == O_CH, s);
                if (s < O_CH) begin
                    wreg[s] = wv;
                end else begin
                    for (int r = 0; r < O_CH; r++) sum[r] += $countones(~(wreg[r] ^ wv));
                end
                send_word(wv, gaps, (g == GROUPS - 1) && (s == O_CH));
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_output("out_valid_latency", 32'(out_valid), 32'd1);
        check_output("in_ready_drain", 32'(in_ready), 32'd0);
        for (int r = 0; r < O_CH; r++) begin
            v           = (sum[r] > 16383) ? 16383 : sum[r];
            exp_full[r] = mode ? int'(v >= THRESH) : v;
            v           = (sum[r] > 2047) ? 2047 : sum[r];
            exp_sat[r]  = mode ? int'(v >= THRESH) : v;
        end
    endtask

    task automatic drain_outputs(input bit stall, input bit toggle_mode);
        out_ready = 1'b1;
        for (int i = 0; i < O_CH; i++) begin
            check_output("out_valid", 32'(out_valid), 32'd1);
            check_output("psum_out", 32'(psum_out), 32'(exp_full[i]));
            check_output("out_last", 32'(out_last), 32'(i == O_CH - 1));
            check_output("psum_out_sat", 32'(psum_out_s), 32'(exp_sat[i]));
            check_output("out_last_sat", 32'(out_last_s), 32'(i == O_CH - 1));
            if (stall && i == 2) begin
                out_ready = 1'b0;
                repeat (3) begin
                    if (toggle_mode) bin_mode = ~bin_mode;
                    @(negedge clk);
                    check_output("stall_psum", 32'(psum_out), 32'(exp_full[i]));
                    check_output("stall_last", 32'(out_last), 32'd0);
                    check_output("stall_valid", 32'(out_valid), 32'd1);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        check_output("out_valid_done", 32'(out_valid), 32'd0);
        check_output("in_ready_done", 32'(in_ready), 32'd1);
        check_output("psum_idle", 32'(psum_out), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        #12;
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_psum", 32'(psum_out), 32'd0);
        check_output("rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("post_rst_in_ready", 32'(in_ready), 32'd1);

        apply_stimulus(0, 1'b0, 1'b0, -1);
        drain_outputs(1'b0, 1'b0);

        apply_stimulus(1, 1'b1, 1'b0, -1);
        drain_outputs(1'b0, 1'b0);
        apply_stimulus(0, 1'b1, 1'b0, -1);
        drain_outputs(1'b0, 1'b0);

        apply_stimulus(2, 1'b0, 1'b0, -1);
        drain_outputs(1'b0, 1'b0);

        apply_stimulus(0, 1'b0, 1'b1, -1);
        drain_outputs(1'b1, 1'b1);

        apply_stimulus(3, 1'b0, 1'b1, 50);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check_output("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check_output("mid_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(0, 1'b0, 1'b0, -1);
        drain_outputs(1'b0, 1'b0);

        repeat (2) begin
            apply_stimulus(3, 1'($urandom_range(0, 1)), 1'b1, -1);
            drain_outputs(1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
